// File: rtl/seed_random_1_pkg.sv
// Shared constants and helpers for the random card generator datapath:
// deck geometry, LFSR taps, card encoding and the 6-bit mod-52 fold.
package seed_random_1_pkg;

  localparam int          DECK_SIZE         = 52;
  localparam int          RANKS             = 13;
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  localparam logic [7:0]  CARD_NONE         = 8'h00;

  // Card code: {2'b00, suit[1:0], rank[3:0]} with rank 1..13.
  function automatic logic [7:0] encode(input logic [5:0] idx);
    logic [1:0] suit;
    logic [5:0] base;
    if (idx < 6'd13) begin
      suit = 2'd0; base = 6'd0;
    end else if (idx < 6'd26) begin
      suit = 2'd1; base = 6'd13;
    end else if (idx < 6'd39) begin
      suit = 2'd2; base = 6'd26;
    end else begin
      suit = 2'd3; base = 6'd39;
    end
    return {2'b00, suit, 4'(idx - base + 6'd1)};
  endfunction

  // Folds 0..63 onto 0..51; 52..63 land on 0..11.
  function automatic logic [5:0] mod52(input logic [5:0] v);
    return (v >= 6'd52) ? v - 6'd52 : v;
  endfunction

endpackage

// File: rtl/seed_random_1_lfsr.sv
// Free-running 16-bit right-shift Galois LFSR; reloads the seed on reset.
module seed_random_1_lfsr
  import seed_random_1_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEED;
    else        state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/seed_random_1_data_path.sv
// Card dealing datapath: picks the first undealt card at or after the LFSR
// candidate (wrapping 51 -> 0), marks it dealt and registers its code.
module seed_random_1_data_path
  import seed_random_1_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk_dp_i,
  input  logic       rst_dp_i,
  input  logic       req_card_state_dp_i,
  output logic [7:0] card_to_send_dp_o
);

  logic [15:0]          lfsr;
  logic [5:0]           cand;
  logic [5:0]           sel;
  logic [6:0]           pos;
  logic [DECK_SIZE-1:0] mask;
  logic [DECK_SIZE-1:0] mask_set;
  logic                 unused_lfsr_hi;

  seed_random_1_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk_dp_i),
    .rst_n (rst_dp_i),
    .state (lfsr)
  );

  assign cand           = mod52(lfsr[5:0]);
  assign unused_lfsr_hi = ^lfsr[15:6];

  // Scan offsets from far to near so the nearest free slot wins.
  always_comb begin
    sel = cand;
    pos = '0;
    for (int k = DECK_SIZE - 1; k >= 0; k--) begin
      pos = {1'b0, cand} + 7'(k);
      if (pos >= 7'(DECK_SIZE)) pos = pos - 7'(DECK_SIZE);
      if (!mask[pos[5:0]]) sel = pos[5:0];
    end
  end

  assign mask_set = mask | ({{(DECK_SIZE-1){1'b0}}, 1'b1} << sel);

  // Dealing the last free card refills the deck on the same edge.
  always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
    if (!rst_dp_i) begin
      mask              <= '0;
      card_to_send_dp_o <= CARD_NONE;
    end else if (req_card_state_dp_i) begin
      mask              <= (&mask_set) ? '0 : mask_set;
      card_to_send_dp_o <= encode(sel);
    end
  end

endmodule

// File: tb/tb_seed_random_1_data_path.sv
// Self-checking bench: hand-computed vector table, card-level reference model
// and directed sequences for deck refill, hold, reset replay and collisions.
module tb_seed_random_1_data_path;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [7:0] card;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [15:0] m_lfsr;
  bit          m_dealt[52];
  int          m_cnt;
  logic [7:0]  m_out;

  typedef struct {
    bit         r;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[8];

  seed_random_1_data_path #(.LFSR_SEED(SEED)) dut (
    .clk_dp_i            (clk),
    .rst_dp_i            (rst_n),
    .req_card_state_dp_i (req),
    .card_to_send_dp_o   (card)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit valid_code(input logic [7:0] c);
    return c[7:6] == 2'b00 && c[3:0] >= 4'd1 && c[3:0] <= 4'd13;
  endfunction

  function automatic logic [7:0] code_of(input int idx);
    return 8'((idx / 13) * 16 + idx % 13 + 1);
  endfunction

  function automatic int cand_of(input logic [15:0] l);
    return int'(l[5:0]) % 52;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED;
    foreach (m_dealt[i]) m_dealt[i] = 1'b0;
    m_cnt = 0;
    m_out = 8'h00;
  endtask

  task automatic model_edge(input bit r);
    int c, idx;
    if (r) begin
      c = cand_of(m_lfsr);
      idx = -1;
      for (int k = 0; k < 52; k++)
        if (idx < 0 && !m_dealt[(c + k) % 52]) idx = (c + k) % 52;
      m_dealt[idx] = 1'b1;
      m_cnt++;
      if (m_cnt == 52) begin
        foreach (m_dealt[i]) m_dealt[i] = 1'b0;
        m_cnt = 0;
      end
      m_out = code_of(idx);
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  // Drives req, lets one edge pass, then compares against the model.
  task automatic tick(input bit r, input string name);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check(name, card, m_out);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases later.
  task automatic do_reset();
    req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", card, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", card, 8'h00);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Idles until the next edge will see candidate c, then deals there.
  task automatic deal_at_cand(input int c, input string name);
    int n;
    n = 0;
    while (cand_of(m_lfsr) != c && n < 4000) begin
      tick(1'b0, "wait_idle");
      n++;
    end
    if (n >= 4000) begin
      tests++;
      fails++;
      $display("FAIL %s: candidate %0d not reached, waited %0d", name, c, n);
    end
    tick(1'b1, name);
  endtask

  initial begin
    bit         seen[64];
    int         cnt[64];
    logic [7:0] held;
    logic [7:0] rec[$];
    bit         pat[$];
    int         deals;

    // hand-derived deals from seed ACE1 starting at the first edge after reset
    vecs[0] = '{1'b1, 8'h28};
    vecs[1] = '{1'b1, 8'h3A};
    vecs[2] = '{1'b1, 8'h05};
    vecs[3] = '{1'b1, 8'h23};
    vecs[4] = '{1'b0, 8'h23};
    vecs[5] = '{1'b1, 8'h31};
    vecs[6] = '{1'b1, 8'h17};
    vecs[7] = '{1'b0, 8'h17};

    model_reset();
    #3;
    check("power_on_reset", card, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req = vecs[i].r;
      @(posedge clk);
      model_edge(vecs[i].r);
      #1;
      check($sformatf("vec%0d", i), card, vecs[i].exp);
    end

    // reset then 20 idle cycles
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b0, "idle_after_reset");
    check("idle_zero", card, 8'h00);

    // 30 back-to-back requests: model match plus pairwise distinct
    do_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1, "deal30");
      check("deal30_valid", valid_code(card), 1);
      check("deal30_distinct", seen[card[5:0]], 0);
      seen[card[5:0]] = 1'b1;
    end

    // full deck: each code exactly once, then refill
    do_reset();
    foreach (cnt[i]) cnt[i] = 0;
    for (int i = 0; i < 52; i++) begin
      tick(1'b1, "deck52");
      cnt[card[5:0]]++;
    end
    for (int i = 0; i < 52; i++) check($sformatf("deck_once_%0d", i), cnt[code_of(i) & 8'h3F], 1);
    tick(1'b1, "deal53");
    check("deal53_valid", valid_code(card), 1);

    // hold: output frozen while idle, next deal tracks the running LFSR
    tick(1'b1, "pre_hold");
    held = card;
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, "hold_model");
      check("hold", card, held);
    end
    tick(1'b1, "after_hold");

    // randomized request pattern against the model
    for (int i = 0; i < 400; i++) tick(($urandom_range(0, 2) != 0), "random");

    // reset mid-deck replays identically
    do_reset();
    pat.push_back(1'b0);
    pat.push_back(1'b0);
    deals = 0;
    while (deals < 10) begin
      pat.push_back(1'($urandom_range(0, 1)));
      if (pat[$]) deals++;
    end
    foreach (pat[j]) begin
      tick(pat[j], "replay_first");
      if (j < 2) check("zero_before_deal", card, 8'h00);
      rec.push_back(card);
    end
    tick(1'b0, "pad");
    do_reset();
    foreach (pat[j]) begin
      tick(pat[j], "replay_second");
      check($sformatf("replay_%0d", j), card, rec[j]);
    end

    // collisions: wrap 51 -> 0 -> 1, and a plain step 20 -> 21
    do_reset();
    deal_at_cand(51, "coll_51");
    check("coll_51_code", card, 8'h3D);
    deal_at_cand(51, "coll_wrap0");
    check("coll_wrap0_code", card, 8'h01);
    deal_at_cand(51, "coll_wrap1");
    check("coll_wrap1_code", card, 8'h02);
    deal_at_cand(20, "coll_20");
    check("coll_20_code", card, 8'h18);
    deal_at_cand(20, "coll_21");
    check("coll_21_code", card, 8'h19);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
